// File: rtl/count_8.sv
// Up/down counter with synchronous parallel load and asynchronous active-low clear.
// The output is taken directly from the count register, so no input has a combinational path to it.
module count_8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: load has priority; otherwise step by one, wrapping modulo 2**WIDTH.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = in;
      end else if (dir) begin
         count_d = count_q + ONE;
      end else begin
         count_d = count_q - ONE;
      end
   end

   // Count register, cleared immediately when rstn falls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= ZERO;
      end else begin
         count_q <= count_d;
      end
   end

   assign out = count_q;

endmodule

// File: tb/tb_count_8.sv
// Scoreboard bench for count_8: stimulus pushes the hand-computed count expected after
// each rising edge; a monitor pops and compares one entry per edge.
module tb_count_8;

   logic       clk = 1'b0;
   logic       rstn;
   logic       dir;
   logic       load;
   logic [7:0] in;
   logic [7:0] out;

   int total = 0;
   int bad   = 0;
   int edge_n = 0;
   logic [7:0] exp_q[$];

   count_8 #(.WIDTH(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .dir  (dir),
      .load (load),
      .in   (in),
      .out  (out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s at %0t: out=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, record the count expected after the next rising edge.
   task automatic step(input logic l, input logic d, input logic [7:0] v, input logic [7:0] e);
      load = l;
      dir  = d;
      in   = v;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: every rising edge yields one count value to compare.
   always @(posedge clk) begin
      #1;
      edge_n = edge_n + 1;
      if (exp_q.size() != 0) begin
         check($sformatf("edge%0d", edge_n), out, exp_q.pop_front());
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not finish, out=%h expected=done", out);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn = 1'b0;
      load = 1'b0;
      dir  = 1'b0;
      in   = 8'h00;
      #1;
      check("reset_before_edge", out, 8'h00);
      exp_q.push_back(8'h00);
      @(negedge clk);

      // Count up 20 edges, then down 10 with no skip at the turnaround.
      rstn = 1'b1;
      for (int i = 1; i <= 20; i++) step(1'b0, 1'b1, 8'hxx, 8'(i));
      for (int i = 19; i >= 10; i--) step(1'b0, 1'b0, 8'hxx, 8'(i));

      // Single-edge load then count down from the loaded value.
      step(1'b1, 1'b0, 8'h26, 8'h26);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h55, 8'(8'h25 - 8'(i)));

      // Wrap-around both ways.
      step(1'b1, 1'b1, 8'hFE, 8'hFE);
      step(1'b0, 1'b1, 8'hxx, 8'hFF);
      step(1'b0, 1'b1, 8'hxx, 8'h00);
      step(1'b0, 1'b1, 8'hxx, 8'h01);
      step(1'b1, 1'b0, 8'h01, 8'h01);
      step(1'b0, 1'b0, 8'hxx, 8'h00);
      step(1'b0, 1'b0, 8'hxx, 8'hFF);
      step(1'b0, 1'b0, 8'hxx, 8'hFE);
      step(1'b1, 1'b0, 8'hFF, 8'hFF);
      step(1'b0, 1'b1, 8'hxx, 8'h00);
      step(1'b1, 1'b1, 8'h00, 8'h00);
      step(1'b0, 1'b0, 8'hxx, 8'hFF);

      // Load held for three edges reloads each time regardless of dir.
      step(1'b1, 1'b1, 8'h5A, 8'h5A);
      step(1'b1, 1'b0, 8'h5A, 8'h5A);
      step(1'b1, 1'b1, 8'h5A, 8'h5A);
      step(1'b0, 1'b1, 8'hxx, 8'h5B);
      step(1'b0, 1'b1, 8'hxx, 8'h5C);

      // Async reset mid-count: clears between edges, inputs ignored while low.
      #2;
      rstn = 1'b0;
      #1;
      check("async_clear_midcount", out, 8'h00);
      exp_q.push_back(8'h00);
      @(negedge clk);
      step(1'b1, 1'b1, 8'hAA, 8'h00);
      step(1'b0, 1'b0, 8'h33, 8'h00);
      rstn = 1'b1;
      step(1'b0, 1'b1, 8'hxx, 8'h01);
      step(1'b0, 1'b1, 8'hxx, 8'h02);
      step(1'b0, 1'b0, 8'hxx, 8'h01);

      // Reset during a pending load aborts it.
      load = 1'b1;
      in   = 8'h77;
      #2;
      rstn = 1'b0;
      #1;
      check("async_clear_during_load", out, 8'h00);
      exp_q.push_back(8'h00);
      @(negedge clk);
      rstn = 1'b1;
      step(1'b0, 1'b0, 8'hxx, 8'hFF);
      step(1'b1, 1'b1, 8'h10, 8'h10);

      @(posedge clk);
      #2;
      total = total + 1;
      if (exp_q.size() != 0) begin
         bad = bad + 1;
         $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/count_8.md
COUNT_8 -- requirements
Module: count_8

Interface
REQ-001 Parameter WIDTH, default 8: counter and data width in bits; all behaviour below is stated for WIDTH=8.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 dir  input  1  count direction: 1 = up (increment), 0 = down (decrement).
REQ-005 load  input  1  synchronous parallel-load strobe, active-high.
REQ-006 in  input  8  parallel-load value.
REQ-007 out  output  8  current count, driven directly from the count register.

Function
REQ-008 One 8-bit count register; out SHALL equal the register at all times, with no combinational path from any input to out.
REQ-009 Priority at each rising clk edge with rstn=1: load, then count.
REQ-010 load=1: register <= in on that edge; dir is ignored on that cycle.
REQ-011 load=0, dir=1: register <= register + 1, modulo 256.
REQ-012 load=0, dir=0: register <= register - 1, modulo 256.
REQ-013 No hold state: with rstn=1, the register changes or reloads on every rising edge.
REQ-014 Up wrap-around: 0xFF SHALL become 0x00 with no flag or stall.
REQ-015 Down wrap-around: 0x00 SHALL become 0xFF with no flag or stall.
REQ-016 A direction change takes effect on the first rising edge after dir settles; there is no extra latency and no skipped count.
REQ-017 Load latency: out SHALL show in one edge after load is sampled high; counting resumes from the loaded value on the next edge.
REQ-018 Load held high for N edges: register SHALL reload in on every one of those edges.
REQ-019 Load value is unrestricted: 0x00 and 0xFF SHALL load and then wrap per REQ-014/015.
REQ-020 in is don't-care while load=0; unknown in SHALL NOT affect the count while load=0.

Reset
REQ-021 rstn=0 SHALL force the register and out to 0x00 immediately, without waiting for a clk edge.
REQ-022 While rstn=0, clk, load, dir and in SHALL have no effect.
REQ-023 Reset asserted mid-count or during load SHALL abort that operation; out = 0x00.
REQ-024 After rstn deasserts, the first rising edge SHALL apply REQ-009..012 starting from 0x00.

Verification
REQ-025 The bench SHALL cover the following scenarios with a 10 ns clk (rising edges at 5, 15, 25 ns, ...):
- rstn=0, load=0, dir=0 at t=0 -> out=0x00 before the first edge and through every edge while rstn=0.
- rstn=1, dir=1 at t=10 ns for 20 edges -> out steps 0x01..0x14, one per edge.
- dir=0 after that for 10 edges -> out steps 0x13..0x0A; no skipped or repeated value at the turnaround.
- load=1, in=0x26 for one edge, then load=0, dir=0 for 10 edges -> out=0x26, then 0x25..0x1C.
- Wrap: load 0xFE, dir=1 -> 0xFF, 0x00, 0x01; load 0x01, dir=0 -> 0x00, 0xFF, 0xFE.
- Async reset mid-count: drop rstn between edges -> out=0x00 at once, before the next edge; stays 0x00 until release; counts from 0x00 after release.
